// File: rtl/cpu_out_uart_tx.sv
// CPU output-port UART transmitter: byte FIFO feeding an 8N1 serialiser, with a status word for polling.
// Optional even-parity bit is enabled by defining CPU_OUT_UART_PARITY_EN.
module cpu_out_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic        TX,
  output logic [31:0] Status
);

  localparam int                PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                TMR_W    = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0]  BIT_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [7:0]        DEPTH8   = 8'(FIFO_DEPTH);

`ifdef CPU_OUT_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]       count_q, count_d;
  logic             overflow_q;
  logic             push, pop;

  state_e           state_q, state_d;
  logic             tx_q, tx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             bit_done;
`ifdef CPU_OUT_UART_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Only the low byte of the store is transmitted.
  logic unused_wd;
  assign unused_wd = ^WD[31:8];

  // Fullness is judged on the registered count, so a same-cycle pop never rescues a write.
  assign push = WE && (count_q != DEPTH8);

  // NOTE: storage has no reset; validity is tracked by count/pointers, so the RAM can map to plain flops or LUT-RAM.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= WD[7:0];
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 8'd1;
      2'b01:   count_d = count_q - 8'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (WE && (count_q == DEPTH8)) overflow_q <= 1'b1;
    end
  end

  assign bit_done = (timer_q == '0);

  // NOTE: every variable gets a default at the top so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef CPU_OUT_UART_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        pop  = (count_q != 8'd0);
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
          timer_d = BIT_LAST;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          timer_d = BIT_LAST;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef CPU_OUT_UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`ifdef CPU_OUT_UART_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          timer_d = BIT_LAST;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          pop     = (count_q != 8'd0);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Loading a byte starts the next frame directly, giving back-to-back frames out of STOP.
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      tx_d    = 1'b0;
      timer_d = BIT_LAST;
      state_d = S_START;
`ifdef CPU_OUT_UART_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef CPU_OUT_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef CPU_OUT_UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign TX     = tx_q;
  assign Status = {16'b0, count_q, 4'b0, overflow_q, (state_q != S_IDLE),
                   (count_q == DEPTH8), (count_q == 8'd0)};

endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// Directed bench for cpu_out_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=8; follows CPU_OUT_UART_PARITY_EN.
module tb_cpu_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef CPU_OUT_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] WD = '0;
  logic        TX;
  logic [31:0] Status;

  int checks = 0;
  int failures = 0;

  cpu_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTn(RSTn), .WE(WE), .WD(WD), .TX(TX), .Status(Status)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-cycle TX waveform of one frame: start, data LSB first, optional even parity, stop.
  function automatic logic [63:0] exp_frame(input logic [7:0] b);
    logic [63:0] v;
    int k;
    v = '0;
    for (int c = 0; c < FRAME_CYC; c++) begin
      k = c / CPB;
      if (k == 0)                         v[c] = 1'b0;
      else if (k <= 8)                    v[c] = b[k-1];
      else if (k == 9 && FRAME_BITS == 11) v[c] = ^b;
      else                                v[c] = 1'b1;
    end
    return v;
  endfunction

  task automatic capture(output logic [63:0] v, output logic busy_all);
    v = '0;
    busy_all = 1'b1;
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge CLK);
      v[c] = TX;
      busy_all = busy_all & Status[2];
    end
  endtask

  task automatic reset_dut();
    RSTn = 1'b0;
    WE   = 1'b0;
    WD   = '0;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic send_one(input logic [7:0] b, input string tag);
    logic [63:0] v;
    logic        busy_all;
    WE = 1'b1;
    WD = {24'hDEADBE, b};
    @(negedge CLK);
    WE = 1'b0;
    check({tag, "_queued"}, Status, 64'h100);
    capture(v, busy_all);
    check({tag, "_frame"}, v, exp_frame(b));
    check({tag, "_busy"}, busy_all, 1);
    @(negedge CLK);
    check({tag, "_status_after"}, Status, 64'h1);
    check({tag, "_tx_after"}, TX, 1);
  endtask

  logic [63:0] got_frames [9];
  int          n;
  logic        all_high;

  initial begin
    // Reset state and quiet idle after release.
    repeat (2) @(negedge CLK);
    check("rst_tx", TX, 1);
    check("rst_status", Status, 64'h1);
    RSTn = 1'b1;
    repeat (5) @(negedge CLK);
    check("idle_tx", TX, 1);
    check("idle_status", Status, 64'h1);

    // Single frames with different bit patterns.
    send_one(8'h55, "b55");
    send_one(8'h07, "b07");
    send_one(8'h03, "b03");

    // Overflow: ten writes on consecutive edges, nine accepted, frames back to back.
    reset_dut();
    WE = 1'b1;
    WD = 32'h0;
    fork
      begin
        for (int i = 1; i < 10; i++) begin
          @(negedge CLK);
          WD = 32'(i);
        end
        @(negedge CLK);
        WE = 1'b0;
        check("ovf_status_full", Status, 64'h80E);
      end
      begin
        logic b_all;
        @(negedge CLK);
        for (int f = 0; f < 9; f++) begin
          capture(got_frames[f], b_all);
          check($sformatf("ovf_busy%0d", f), b_all, 1);
        end
      end
    join
    for (int f = 0; f < 9; f++)
      check($sformatf("ovf_frame%0d", f), got_frames[f], exp_frame(8'(f)));
    @(negedge CLK);
    check("ovf_status_idle", Status, 64'h9);

    // Full FIFO with a write landing on the STOP->START pop edge.
    reset_dut();
    WE = 1'b1;
    WD = 32'hA0;
    for (int i = 1; i < 9; i++) begin
      @(negedge CLK);
      WD = 32'hA0 + 32'(i);
    end
    @(negedge CLK);
    WE = 1'b0;
    repeat (FRAME_CYC - 8) @(negedge CLK);
    check("fullpop_before", Status, 64'h806);
    WE = 1'b1;
    WD = 32'hEE;
    @(negedge CLK);
    WE = 1'b0;
    check("fullpop_after", Status, 64'h70C);
    check("fullpop_tx_start", TX, 0);
    n = 0;
    while (Status[2] && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("fullpop_drain_cycles", n, 8 * FRAME_CYC);
    check("fullpop_status_idle", Status, 64'h9);

    // Reset during data bit 3 aborts the frame and discards the queue.
    reset_dut();
    WE = 1'b1;
    WD = 32'h0;
    @(negedge CLK);
    WD = 32'h0;
    @(negedge CLK);
    WE = 1'b0;
    repeat (17) @(negedge CLK);
    check("midrst_bit3_low", TX, 0);
    #1 RSTn = 1'b0;
    #1;
    check("midrst_tx_async", TX, 1);
    check("midrst_status", Status, 64'h1);
    @(negedge CLK);
    RSTn = 1'b1;
    all_high = 1'b1;
    repeat (3 * FRAME_CYC) begin
      @(negedge CLK);
      all_high = all_high & TX;
    end
    check("midrst_no_frame", all_high, 1);
    check("midrst_status_after", Status, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
